// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU constants for the pipeline hazard sequencer.
//   REG_LOG : width of an architectural register number
//   WORD    : datapath / PC width
//   ST_*    : 2-bit encodings of the hazard controller FSM
package pipeline_hazard_ctrl_pkg;

    localparam int REG_LOG = 5;
    localparam int WORD    = 32;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_DIV        = 2'd1;
    localparam logic [1:0] ST_REDIR_HOLD = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use compare between the ID-stage
// source operands and the destination of a load sitting in EX.
//   id_rj, id_rk         : ID source register numbers
//   id_use_rj, id_use_rk : ID instruction actually reads that operand
//   ex_rd, ex_is_load    : EX destination and load flag
//   load_use             : a one-cycle bubble is required
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_LOG-1:0] id_rj,
    input  logic [REG_LOG-1:0] id_rk,
    input  logic               id_use_rj,
    input  logic               id_use_rk,
    input  logic [REG_LOG-1:0] ex_rd,
    input  logic               ex_is_load,
    output logic               load_use
);

    logic rj_hit;
    logic rk_hit;

    assign rj_hit = id_use_rj && (id_rj == ex_rd);
    assign rk_hit = id_use_rk && (id_rk == ex_rd);

    // r0 is hard-wired to zero, so a load targeting it never creates a hazard
    assign load_use = ex_is_load && (ex_rd != '0) && (rj_hit || rk_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Merges DCache/ICache stalls, load-use hazards, the multi-cycle divider and
// EX-stage redirects into per-register stall (hold) and flush (bubble) strobes.
//   clk, rst                      : clock, synchronous active-high reset
//   icache_stall, dcache_stall    : cache misses in progress
//   id_rj/id_rk, id_use_rj/rk     : ID operands
//   ex_rd, ex_is_load             : EX destination / load flag
//   ex_div_start                  : new divide issued in EX (pulse)
//   ex_redirect, ex_target        : EX mispredict and its target
//   pc_stall, stall_*             : hold the register
//   flush_*                       : load a bubble into the register
//   redirect_valid, redirect_pc   : registered one-cycle PC redirect
//   div_busy                      : divider occupying EX
//   stall_cnt                     : wrapping count of pc_stall cycles
//
// state      | meaning
// -----------+---------------------------------------------------------
// RUN        | normal flow; combinational hazards only
// DIV        | divide in EX; upstream held, EX_MEM fed bubbles
// REDIR_HOLD | redirect target latched, waiting for ICache miss to end
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 16,
    parameter int PERF_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               icache_stall,
    input  logic               dcache_stall,
    input  logic [REG_LOG-1:0] id_rj,
    input  logic [REG_LOG-1:0] id_rk,
    input  logic               id_use_rj,
    input  logic               id_use_rk,
    input  logic [REG_LOG-1:0] ex_rd,
    input  logic               ex_is_load,
    input  logic               ex_div_start,
    input  logic               ex_redirect,
    input  logic [WORD-1:0]    ex_target,
    output logic               pc_stall,
    output logic               stall_if_id,
    output logic               stall_id_ex,
    output logic               stall_ex_mem,
    output logic               flush_if_id,
    output logic               flush_id_ex,
    output logic               flush_ex_mem,
    output logic               flush_mem_wb,
    output logic               redirect_valid,
    output logic [WORD-1:0]    redirect_pc,
    output logic               div_busy,
    output logic [PERF_W-1:0]  stall_cnt
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] div_cnt;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .id_rj      (id_rj),
        .id_rk      (id_rk),
        .id_use_rj  (id_use_rj),
        .id_use_rk  (id_use_rk),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .load_use   (load_use)
    );

    assign div_busy = (state == ST_DIV);

    // Exactly one hazard source shapes the strobes each cycle, so a register
    // is never asked to stall and flush at the same time.
    always_comb begin
        pc_stall     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        if (dcache_stall) begin
            pc_stall     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (state == ST_DIV) begin
            pc_stall     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (state == ST_REDIR_HOLD) begin
            // Keep the wrong-path fetch out of IF_ID until the target can be issued
            pc_stall    = 1'b1;
            flush_if_id = 1'b1;
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (icache_stall) begin
            pc_stall    = 1'b1;
            flush_if_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            div_cnt        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall_cnt      <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (pc_stall) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            case (state)
                ST_RUN: begin
                    if (!dcache_stall) begin
                        // A divide cannot also be a branch; the divide is honoured first
                        if (ex_div_start) begin
                            state   <= ST_DIV;
                            div_cnt <= CNT_INIT;
                        end else if (ex_redirect) begin
                            redirect_pc <= ex_target;
                            if (icache_stall) begin
                                state <= ST_REDIR_HOLD;
                            end else begin
                                redirect_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_DIV: begin
                    // The divider is frozen along with EX while MEM waits on the DCache
                    if (!dcache_stall) begin
                        if (div_cnt == '0) begin
                            state <= ST_RUN;
                        end else begin
                            div_cnt <= div_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_REDIR_HOLD: begin
                    if (!icache_stall) begin
                        state          <= ST_RUN;
                        redirect_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int DIVC = 4;
    localparam int PW   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_stall, dcache_stall;
    logic [4:0]  id_rj, id_rk, ex_rd;
    logic        id_use_rj, id_use_rk, ex_is_load, ex_div_start, ex_redirect;
    logic [31:0] ex_target;
    logic        pc_stall, stall_if_id, stall_id_ex, stall_ex_mem;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic        redirect_valid, div_busy;
    logic [31:0] redirect_pc;
    logic [PW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DIV_CYCLES(DIVC), .PERF_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_stall   (icache_stall),
        .dcache_stall   (dcache_stall),
        .id_rj          (id_rj),
        .id_rk          (id_rk),
        .id_use_rj      (id_use_rj),
        .id_use_rk      (id_use_rk),
        .ex_rd          (ex_rd),
        .ex_is_load     (ex_is_load),
        .ex_div_start   (ex_div_start),
        .ex_redirect    (ex_redirect),
        .ex_target      (ex_target),
        .pc_stall       (pc_stall),
        .stall_if_id    (stall_if_id),
        .stall_id_ex    (stall_id_ex),
        .stall_ex_mem   (stall_ex_mem),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .flush_ex_mem   (flush_ex_mem),
        .flush_mem_wb   (flush_mem_wb),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .div_busy       (div_busy),
        .stall_cnt      (stall_cnt)
    );

    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";

    // Reference model: divide remaining-cycle budget, pending-redirect flag
    int          m_div_left;
    bit          m_hold;
    bit          m_rv;
    logic [31:0] m_rpc;
    int          m_cnt;

    int          busy_seen;
    int          rv_seen;
    logic [31:0] rv_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe vector {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex, ex_mem, mem_wb flushes}
    function automatic logic [7:0] exp_strobes();
        bit lu;
        lu = ex_is_load && (ex_rd != 0) &&
             ((id_use_rj && id_rj == ex_rd) || (id_use_rk && id_rk == ex_rd));
        if (dcache_stall)        return 8'b1111_0001;
        else if (m_div_left > 0) return 8'b1110_0010;
        else if (m_hold)         return 8'b1000_1000;
        else if (ex_redirect)    return 8'b0000_1100;
        else if (lu)             return 8'b1100_0100;
        else if (icache_stall)   return 8'b1000_1000;
        return 8'b0000_0000;
    endfunction

    task automatic model_reset();
        m_div_left = 0;
        m_hold     = 0;
        m_rv       = 0;
        m_rpc      = 32'h0;
        m_cnt      = 0;
    endtask

    task automatic tick();
        logic [7:0] es;
        bit nrv;
        #1;
        es = exp_strobes();
        chk({phase, " strobes"},
            {56'h0, pc_stall, stall_if_id, stall_id_ex, stall_ex_mem,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}, {56'h0, es});
        chk({phase, " redirect_valid"}, {63'h0, redirect_valid}, {63'h0, m_rv});
        chk({phase, " redirect_pc"}, {32'h0, redirect_pc}, {32'h0, m_rpc});
        chk({phase, " div_busy"}, {63'h0, div_busy}, {63'h0, (m_div_left > 0)});
        chk({phase, " stall_cnt"}, {56'h0, stall_cnt}, 64'(m_cnt));
        if (div_busy) busy_seen++;
        if (redirect_valid) begin
            rv_seen++;
            rv_pc = redirect_pc;
        end
        if (rst) begin
            model_reset();
        end else begin
            nrv = 0;
            if (es[7]) m_cnt = (m_cnt + 1) % (1 << PW);
            if (m_div_left > 0) begin
                if (!dcache_stall) m_div_left--;
            end else if (m_hold) begin
                if (!icache_stall) begin
                    m_hold = 0;
                    nrv    = 1;
                end
            end else if (!dcache_stall) begin
                if (ex_div_start) begin
                    m_div_left = DIVC;
                end else if (ex_redirect) begin
                    m_rpc = ex_target;
                    if (icache_stall) m_hold = 1;
                    else nrv = 1;
                end
            end
            m_rv = nrv;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst          = 1'b0;
        icache_stall = 1'b0;
        dcache_stall = 1'b0;
        id_rj        = 5'd0;
        id_rk        = 5'd0;
        id_use_rj    = 1'b0;
        id_use_rk    = 1'b0;
        ex_rd        = 5'd0;
        ex_is_load   = 1'b0;
        ex_div_start = 1'b0;
        ex_redirect  = 1'b0;
        ex_target    = 32'h0;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);

        phase = "reset";
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset pc_stall", {63'h0, pc_stall}, 64'h0);
        chk("reset stall_cnt", {56'h0, stall_cnt}, 64'h0);

        phase = "load_use";
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rj = 5'd5; id_use_rj = 1'b1;
        #1;
        chk("lu pc_stall", {63'h0, pc_stall}, 64'h1);
        chk("lu flush_id_ex", {63'h0, flush_id_ex}, 64'h1);
        tick();
        idle();
        tick();

        phase = "x0";
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rj = 5'd0; id_use_rj = 1'b1;
        tick();
        idle();

        phase = "div";
        ex_div_start = 1'b1;
        tick();
        ex_div_start = 1'b0;
        busy_seen = 0;
        repeat (8) tick();
        chk("div busy length", 64'(busy_seen), 64'(DIVC));

        phase = "div_dcache";
        ex_div_start = 1'b1;
        tick();
        ex_div_start = 1'b0;
        busy_seen = 0;
        tick();
        tick();
        dcache_stall = 1'b1;
        repeat (3) tick();
        dcache_stall = 1'b0;
        repeat (8) tick();
        chk("div+dcache busy length", 64'(busy_seen), 64'(DIVC + 3));

        phase = "redir_hold";
        ex_redirect = 1'b1; ex_target = 32'h1C00_0100; icache_stall = 1'b1;
        tick();
        ex_redirect = 1'b0; ex_target = 32'hDEAD_BEEF;
        repeat (4) tick();
        icache_stall = 1'b0;
        rv_seen = 0;
        #1;
        chk("hold no early redirect", {63'h0, redirect_valid}, 64'h0);
        repeat (3) tick();
        chk("hold redirect pulses", 64'(rv_seen), 64'h1);
        chk("hold redirect target", {32'h0, rv_pc}, 64'h1C00_0100);

        phase = "dcache_combo";
        dcache_stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h1C00_0200;
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rk = 5'd7; id_use_rk = 1'b1;
        rv_seen = 0;
        repeat (3) tick();
        chk("combo no redirect in stall", 64'(rv_seen), 64'h0);
        dcache_stall = 1'b0;
        tick();
        idle();
        repeat (2) tick();
        chk("combo redirect after stall", 64'(rv_seen), 64'h1);
        chk("combo redirect target", {32'h0, rv_pc}, 64'h1C00_0200);

        phase = "rst_in_div";
        ex_div_start = 1'b1;
        tick();
        ex_div_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_div div_busy", {63'h0, div_busy}, 64'h0);
        chk("rst_in_div stall_cnt", {56'h0, stall_cnt}, 64'h0);
        tick();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            dcache_stall = ($urandom_range(0, 7) == 0);
            icache_stall = ($urandom_range(0, 4) == 0);
            ex_redirect  = ($urandom_range(0, 9) == 0);
            ex_div_start = !ex_redirect && ($urandom_range(0, 11) == 0);
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_rd        = 5'($urandom_range(0, 7));
            id_rj        = 5'($urandom_range(0, 7));
            id_rk        = 5'($urandom_range(0, 7));
            id_use_rj    = 1'($urandom_range(0, 1));
            id_use_rk    = 1'($urandom_range(0, 1));
            ex_target    = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
